// File: rtl/instr_mem_if.sv
// Fetch and program-load bus between the CPU front end and the loadable instruction store.
// The memory side is the slave; the PC stage and the program loader together form the master.
interface instr_mem_if #(
    parameter int INSTR_WIDTH = 19,
    parameter int ADDR_WIDTH  = 12
);
    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   fetch_valid;
    logic                   fetch_err;
    logic                   busy;
    logic                   load_start;
    logic [ADDR_WIDTH-1:0]  load_base;
    logic [ADDR_WIDTH:0]    load_len;
    logic                   load_valid;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_ready;
    logic                   load_done;

    modport master (
        output fetch_req, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
        input  instruction, fetch_valid, fetch_err, busy, load_ready, load_done
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
        output instruction, fetch_valid, fetch_err, busy, load_ready, load_done
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction store: zeroing sweep after reset, streamed program load,
// and a one-cycle registered fetch port for the PC stage.
module instr_mem_loadable #(
    parameter int INSTR_WIDTH = 19,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    instr_mem_if.slave  bus
);
    localparam int                    MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0]     LAST_IDX = MEM_AW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

    state_t                 r_state, w_state_next;
    logic [MEM_AW-1:0]      r_clr_ptr, w_clr_ptr_next;
    logic [MEM_AW-1:0]      r_wr_ptr, w_wr_ptr_next;
    logic [ADDR_WIDTH:0]    r_remaining, w_remaining_next;
    logic                   r_fetch_valid, r_fetch_err, r_load_done, r_instr_zero;
    logic [INSTR_WIDTH-1:0] r_ram_q;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

    logic                   w_busy, w_load_ready, w_fetch_acc, w_fetch_oob, w_load_fire;
    logic                   w_we;
    logic [MEM_AW-1:0]      w_waddr;
    logic [INSTR_WIDTH-1:0] w_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_CLEAR;
            r_clr_ptr     <= '0;
            r_wr_ptr      <= '0;
            r_remaining   <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_load_done   <= 1'b0;
            r_instr_zero  <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_clr_ptr     <= w_clr_ptr_next;
            r_wr_ptr      <= w_wr_ptr_next;
            r_remaining   <= w_remaining_next;
            r_fetch_valid <= w_fetch_acc;
            r_fetch_err   <= w_fetch_acc && w_fetch_oob;
            r_load_done   <= (r_state == S_LOAD) && (w_state_next == S_IDLE);
            // Out-of-range fetches force the output word to zero until the next fetch.
            if (w_fetch_acc) begin
                r_instr_zero <= w_fetch_oob;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clr_ptr_next   = r_clr_ptr;
        w_wr_ptr_next    = r_wr_ptr;
        w_remaining_next = r_remaining;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_next   = S_IDLE;
                    w_clr_ptr_next = '0;
                end else begin
                    w_clr_ptr_next = r_clr_ptr + MEM_AW'(1);
                end
            end
            S_IDLE: begin
                if (bus.load_start) begin
                    w_state_next     = S_LOAD;
                    w_wr_ptr_next    = bus.load_base[MEM_AW-1:0];
                    w_remaining_next = bus.load_len;
                end
            end
            S_LOAD: begin
                if (r_remaining == '0) begin
                    w_state_next = S_IDLE;
                end else if (w_load_fire) begin
                    w_remaining_next = r_remaining - LEN_ONE;
                    w_wr_ptr_next    = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + MEM_AW'(1);
                    if (r_remaining == LEN_ONE) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_CLEAR;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_load_ready = (r_state == S_LOAD) && (r_remaining != '0);
        w_fetch_acc  = (r_state == S_IDLE) && bus.fetch_req;
        w_fetch_oob  = ({1'b0, bus.fetch_addr} >= DEPTH_W);
        w_load_fire  = w_load_ready && bus.load_valid;
        w_we         = 1'b0;
        w_waddr      = r_clr_ptr;
        w_wdata      = '0;
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
        end else if (w_load_fire) begin
            w_we    = 1'b1;
            w_waddr = r_wr_ptr;
            w_wdata = bus.load_data;
        end
    end

    // Plain array with enabled registered read so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (w_fetch_acc) begin
            r_ram_q <= r_mem[bus.fetch_addr[MEM_AW-1:0]];
        end
    end

    assign bus.instruction = r_instr_zero ? '0 : r_ram_q;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.busy        = w_busy;
    assign bus.load_ready  = w_load_ready;
    assign bus.load_done   = r_load_done;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable at DEPTH=16: sweep, load/read-back, wrap,
// out-of-range fetch, same-cycle fetch+load, empty load and reset during a load.
module tb_instr_mem_loadable;
    localparam int IW = 19;
    localparam int AW = 12;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [IW-1:0] ld_words [4];

    always #5 clk = ~clk;

    instr_mem_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    instr_mem_loadable #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [31:0] exp, input logic err);
        string tag;
        tag = $sformatf("fetch[%0d]", a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_req  = 1'b0;
        check({tag, "/valid"}, 32'(bus.fetch_valid), 32'd1);
        check({tag, "/err"},   32'(bus.fetch_err),   32'(err));
        check({tag, "/data"},  32'(bus.instruction), exp);
    endtask

    task automatic sweep_wait(input string tag);
        int cnt = 0;
        int fv  = 0;
        int dn  = 0;
        while (bus.busy === 1'b1 && cnt < 64) begin
            tick();
            cnt++;
            if (bus.fetch_valid === 1'b1) fv++;
            if (bus.load_done === 1'b1) dn++;
        end
        check({tag, "/busy_cycles"}, 32'(cnt), 32'(DP));
        check({tag, "/fetch_while_busy"}, 32'(fv), 32'd0);
        check({tag, "/done_while_busy"}, 32'(dn), 32'd0);
    endtask

    task automatic load(input logic [AW-1:0] base, input int len, input int gap, input string tag);
        int   i   = 0;
        int   cyc = 0;
        int   dn  = 0;
        logic rdy;
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_len   = 13'(len);
        tick();
        bus.load_start = 1'b0;
        check({tag, "/busy"},  32'(bus.busy), 32'd1);
        check({tag, "/ready"}, 32'(bus.load_ready), 32'd1);
        while (i < len && cyc < 40) begin
            rdy = bus.load_ready;
            if (cyc == gap) begin
                bus.load_valid = 1'b0;
            end else begin
                bus.load_valid = 1'b1;
                bus.load_data  = ld_words[i];
            end
            tick();
            if (bus.load_valid && rdy) i++;
            if (bus.load_done === 1'b1) dn++;
            cyc++;
        end
        bus.load_valid = 1'b0;
        check({tag, "/cycles"},     32'(cyc), 32'(len + ((gap >= 0) ? 1 : 0)));
        check({tag, "/done_count"}, 32'(dn), 32'd1);
        check({tag, "/done_last"},  32'(bus.load_done), 32'd1);
        check({tag, "/busy_end"},   32'(bus.busy), 32'd0);
        check({tag, "/ready_end"},  32'(bus.load_ready), 32'd0);
        tick();
        check({tag, "/done_pulse"}, 32'(bus.load_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        tick();
        tick();
        check("reset/busy",        32'(bus.busy), 32'd1);
        check("reset/fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("reset/fetch_err",   32'(bus.fetch_err), 32'd0);
        check("reset/instruction", 32'(bus.instruction), 32'd0);
        check("reset/load_ready",  32'(bus.load_ready), 32'd0);
        check("reset/load_done",   32'(bus.load_done), 32'd0);

        // Requests during the sweep must be ignored.
        rst            = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 12'd5;
        sweep_wait("sweep");
        bus.fetch_req  = 1'b0;
        for (int a = 0; a < DP; a++) fetch(12'(a), 32'h0, 1'b0);

        ld_words[0] = 19'h1A064;
        ld_words[1] = 19'h1A166;
        ld_words[2] = 19'h00A46;
        ld_words[3] = 19'h1B068;
        load(12'd2, 4, 1, "load");
        fetch(12'd2, 32'h1A064, 1'b0);
        fetch(12'd3, 32'h1A166, 1'b0);
        fetch(12'd4, 32'h00A46, 1'b0);
        fetch(12'd5, 32'h1B068, 1'b0);
        fetch(12'd1, 32'h0, 1'b0);
        fetch(12'd6, 32'h0, 1'b0);

        fetch(12'd2, 32'h1A064, 1'b0);
        tick();
        check("hold/valid", 32'(bus.fetch_valid), 32'd0);
        check("hold/data",  32'(bus.instruction), 32'h1A064);

        fetch(12'd20, 32'h0, 1'b1);
        tick();
        check("oob_after/err",  32'(bus.fetch_err), 32'd0);
        check("oob_after/data", 32'(bus.instruction), 32'h0);

        ld_words[0] = 19'd1;
        ld_words[1] = 19'd2;
        ld_words[2] = 19'd3;
        ld_words[3] = 19'd4;
        load(12'd14, 4, -1, "wrap");
        fetch(12'd14, 32'd1, 1'b0);
        fetch(12'd15, 32'd2, 1'b0);
        fetch(12'd0,  32'd3, 1'b0);
        fetch(12'd1,  32'd4, 1'b0);
        fetch(12'd2,  32'h1A064, 1'b0);

        // Same-cycle fetch and load start: fetch sees pre-load contents.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 12'd3;
        bus.load_start = 1'b1;
        bus.load_base  = 12'd3;
        bus.load_len   = 13'd1;
        tick();
        bus.load_start = 1'b0;
        check("same/valid", 32'(bus.fetch_valid), 32'd1);
        check("same/data",  32'(bus.instruction), 32'h1A166);
        check("same/busy",  32'(bus.busy), 32'd1);
        check("same/ready", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = 19'h12345;
        tick();
        bus.load_valid = 1'b0;
        bus.fetch_req  = 1'b0;
        check("same/done",          32'(bus.load_done), 32'd1);
        check("same/busy_end",      32'(bus.busy), 32'd0);
        check("same/no_fetch_load", 32'(bus.fetch_valid), 32'd0);
        tick();
        check("same/done_pulse", 32'(bus.load_done), 32'd0);
        fetch(12'd3, 32'h12345, 1'b0);

        bus.load_start = 1'b1;
        bus.load_base  = 12'd0;
        bus.load_len   = 13'd0;
        tick();
        bus.load_start = 1'b0;
        check("len0/t1_busy",  32'(bus.busy), 32'd1);
        check("len0/t1_ready", 32'(bus.load_ready), 32'd0);
        check("len0/t1_done",  32'(bus.load_done), 32'd0);
        tick();
        check("len0/t2_done",  32'(bus.load_done), 32'd1);
        check("len0/t2_busy",  32'(bus.busy), 32'd0);
        check("len0/t2_ready", 32'(bus.load_ready), 32'd0);

        // Reset after two of four words: everything is swept back to zero.
        bus.load_start = 1'b1;
        bus.load_base  = 12'd0;
        bus.load_len   = 13'd4;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 19'h0AAAA;
        tick();
        bus.load_data  = 19'h05555;
        tick();
        bus.load_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid/busy",  32'(bus.busy), 32'd1);
        check("rstmid/ready", 32'(bus.load_ready), 32'd0);
        check("rstmid/done",  32'(bus.load_done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        sweep_wait("rstmid_sweep");
        fetch(12'd0,  32'h0, 1'b0);
        fetch(12'd1,  32'h0, 1'b0);
        fetch(12'd2,  32'h0, 1'b0);
        fetch(12'd3,  32'h0, 1'b0);
        fetch(12'd14, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the multi-cycle/pipelined CPU datapath; successor to the fixed 4096x19 instruction store. Power-up contents are zeroed by a hardware sweep, and a word-streaming load port writes programs at runtime. A registered fetch port serves the PC stage. Instruction width, address width and depth are all parameters.

## Interface
- INSTR_WIDTH, 19, instruction word width in bits
- ADDR_WIDTH, 12, fetch/load address width
- DEPTH, 4096, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request, sampled in IDLE only
- fetch_addr  in  ADDR_WIDTH  fetch word address
- instruction  out  INSTR_WIDTH  fetched word, registered
- fetch_valid  out  1  one-cycle pulse, instruction valid
- fetch_err  out  1  qualifies fetch_valid; set when fetch_addr >= DEPTH
- busy  out  1  high in CLEAR and LOAD; fetches are not served while high
- load_start  in  1  begin a load; sampled in IDLE only
- load_base  in  ADDR_WIDTH  first write address, must be < DEPTH; sampled with load_start
- load_len  in  ADDR_WIDTH+1  number of words to load, 0..DEPTH; sampled with load_start
- load_valid  in  1  load_data is valid
- load_data  in  INSTR_WIDTH  word to write
- load_ready  out  1  high in LOAD; a word is written when load_valid && load_ready
- load_done  out  1  one-cycle pulse when a load completes

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- Async reset values:
  - state=CLEAR, clr_ptr=0
  - instruction=0, fetch_valid=0, fetch_err=0, load_done=0
  - busy=1, load_ready=0
- CLEAR:
  - Write 0 to mem[clr_ptr] each cycle, then increment clr_ptr.
  - After writing DEPTH-1, go to IDLE. The sweep takes exactly DEPTH cycles.
  - fetch_req and load_start are ignored.
- IDLE:
  - fetch_req=1: on the next cycle fetch_valid=1 and instruction=mem[fetch_addr], with fetch_err=0.
  - If fetch_addr >= DEPTH: instruction=0 and fetch_err=1.
  - instruction holds its last value when fetch_valid=0.
  - load_start=1: capture wr_ptr=load_base and remaining=load_len, then go to LOAD.
  - fetch_req and load_start in the same cycle: the fetch is served, and the FSM enters LOAD.
- LOAD:
  - load_ready=1 while remaining != 0.
  - On each handshake, mem[wr_ptr] <= load_data and remaining decrements.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - When the final word is written, or on the first LOAD cycle if load_len=0, go to IDLE and pulse load_done.
  - fetch_req and load_start are ignored. The requester holds fetch_req until busy=0.
- Mid-operation reset: any state returns to CLEAR. The partially loaded program is discarded and zeroed.
- Writes only come from CLEAR or LOAD, so a fetch never overlaps a write.

## Timing
- Fetch latency: 1 cycle, from fetch_req sampled to fetch_valid. Throughput is one fetch per cycle in IDLE.
- busy is registered and equal to (state != IDLE).
- After reset release, busy falls DEPTH cycles later, and the first fetch is accepted on that cycle.
- Load of N >= 1 words with no stalls:
  - load_start at cycle t.
  - load_ready high from t+1 through t+N.
  - load_done pulses at t+N+1, together with busy=0.
  - Stalls (load_valid=0) extend the load 1:1.
- load_len=0: load_done at t+2, and load_ready never asserts.
- load_done, fetch_valid and fetch_err are registered single-cycle pulses.

## Test plan
- Reset sweep (DEPTH=16): busy=1 for 16 cycles after rst falls. Fetches at addresses 0..15 then return 0 with fetch_valid 1 cycle later, and fetch_req during busy yields no fetch_valid.
- Load and read-back: load_base=2, load_len=4, words 0x1A064, 0x1A166, 0x00A46, 0x1B068 with one inserted load_valid=0 gap. load_done pulses once, and fetches of 2..5 return the same words in order.
- Wrap: DEPTH=16, load_base=14, load_len=4, data 1,2,3,4. Address 14=1, 15=2, 0=3, 1=4, and address 2 is unchanged.
- Out of range: DEPTH=16, ADDR_WIDTH=12, fetch_addr=20 gives fetch_valid=1, fetch_err=1, instruction=0.
- Reset mid-load: rst asserted after 2 of 4 words. Busy goes high, the sweep repeats, all words read 0, and load_done never pulses.
- Same-cycle fetch_req+load_start in IDLE: the fetch returns the old data the next cycle, and the LOAD then proceeds normally. load_len=0 gives load_done at t+2.
